// File: rtl/cart_swap_ctrl.sv
// cart_swap_ctrl
//   Sequences cartridge hot-swap and custom-cartridge download, and arbitrates
//   the single cartridge memory port between the OSD downloader (absolute
//   priority) and the Z80 cartridge window 0x4000-0xBFFF. Owns the system
//   reset hold for CPU/PIO/VDP and releases it only on a ce_vid boundary.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   ce_vid              video clock enable; reset release aligns to it
//   cart_select         selected cartridge ID
//   dn_wr/index/addr/data  downloader write port
//   cpu_addr/rd_n/mreq_n   Z80 bus
//   mem_addr/we/wdata   cartridge memory port (combinational)
//   mem_rdata           cartridge memory read data, 1-cycle synchronous
//   cpu_rdata           data to the CPU read mux (0 outside the window)
//   cart_hit            previous cycle was a CPU read inside the window
//   sys_reset           registered reset for CPU, PIO, VDP
//   busy                registered, high while in SWAP or DL
//   dl_count            bytes accepted in the current or last download
module cart_swap_ctrl #(
   parameter int          ADDR_W         = 15,
   parameter logic [7:0]  CART_INDEX     = 8'd1,
   parameter int          SETTLE_CYCLES  = 16,
   parameter int          DL_IDLE_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce_vid,
   input  logic [3:0]        cart_select,
   input  logic              dn_wr,
   input  logic [7:0]        dn_index,
   input  logic [15:0]       dn_addr,
   input  logic [7:0]        dn_data,
   input  logic [15:0]       cpu_addr,
   input  logic              cpu_rd_n,
   input  logic              cpu_mreq_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        cpu_rdata,
   output logic              cart_hit,
   output logic              sys_reset,
   output logic              busy,
   output logic [15:0]       dl_count
);

   localparam int HOLD_W = $clog2(SETTLE_CYCLES + 1);
   localparam int IDLE_W = $clog2(DL_IDLE_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SETTLE_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DL_IDLE_CYCLES - 1);

   typedef enum logic [1:0] {ST_RUN, ST_SWAP, ST_DL, ST_RELEASE} state_t;

   state_t            state_q, state_n;
   logic [HOLD_W-1:0] hold_q, hold_n;
   logic [IDLE_W-1:0] idle_q, idle_n;
   logic              pend_q, pend_n;
   logic [15:0]       dlc_q, dlc_n;
   logic [3:0]        cart_current;

   logic        dl_act, dl_match, sel_chg, win_rd;
   logic [15:0] cpu_off;

   // dl_act: any write to our index (activity); dl_match: one that lands in memory
   assign dl_act   = dn_wr && (dn_index == CART_INDEX);
   assign dl_match = dl_act && !dn_addr[15];
   assign sel_chg  = (cart_select != cart_current);
   assign win_rd   = !cpu_mreq_n && !cpu_rd_n &&
                     (cpu_addr >= 16'h4000) && (cpu_addr < 16'hC000);
   assign cpu_off  = cpu_addr - 16'h4000;

   assign mem_we    = dl_match && !reset;
   assign mem_addr  = dl_match ? dn_addr[ADDR_W-1:0] : cpu_off[ADDR_W-1:0];
   assign mem_wdata = dn_data;
   assign cpu_rdata = cart_hit ? mem_rdata : 8'h00;
   assign dl_count  = dlc_q;

   always_comb begin
      state_n = state_q;
      hold_n  = hold_q;
      idle_n  = idle_q;
      pend_n  = pend_q;
      dlc_n   = dlc_q;
      case (state_q)
         ST_RUN, ST_RELEASE: begin
            if (dl_act) begin
               state_n = ST_DL;
               pend_n  = pend_q | sel_chg;
            end else if (sel_chg) begin
               state_n = ST_SWAP;
               hold_n  = HOLD_LOAD;
            end else if (state_q == ST_RELEASE && ce_vid) begin
               state_n = ST_RUN;
            end
         end
         ST_SWAP: begin
            if (dl_act) begin
               state_n = ST_DL;
               pend_n  = 1'b1;
            end else if (sel_chg) begin
               hold_n = HOLD_LOAD;
            end else if (hold_q == '0) begin
               state_n = ST_RELEASE;
            end else begin
               hold_n = hold_q - 1'b1;
            end
         end
         ST_DL: begin
            pend_n = pend_q | sel_chg;
            if (!dl_act && idle_q == IDLE_LAST) begin
               pend_n = 1'b0;
               if (pend_q || sel_chg) begin
                  state_n = ST_SWAP;
                  hold_n  = HOLD_LOAD;
               end else begin
                  state_n = ST_RELEASE;
               end
            end
         end
         default: state_n = ST_RELEASE;
      endcase

      // Download bookkeeping is shared by every entry path into DL, so it is
      // keyed on the next state rather than repeated in each branch above.
      if (state_n == ST_DL) begin
         if (state_q != ST_DL) begin
            idle_n = '0;
            dlc_n  = dl_match ? 16'd1 : 16'd0;
         end else begin
            idle_n = dl_act ? '0 : idle_q + 1'b1;
            if (dl_match && dlc_q != 16'hFFFF)
               dlc_n = dlc_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_RELEASE;
         hold_q       <= '0;
         idle_q       <= '0;
         pend_q       <= 1'b0;
         dlc_q        <= '0;
         cart_current <= cart_select;
         cart_hit     <= 1'b0;
         sys_reset    <= 1'b1;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_n;
         hold_q       <= hold_n;
         idle_q       <= idle_n;
         pend_q       <= pend_n;
         dlc_q        <= dlc_n;
         cart_current <= cart_select;
         cart_hit     <= win_rd;
         sys_reset    <= (state_q != ST_RUN);
         busy         <= (state_q == ST_SWAP) || (state_q == ST_DL);
      end
   end

endmodule

// File: tb/tb_cart_swap_ctrl.sv
module tb_cart_swap_ctrl;

   localparam int S = 16;
   localparam int D = 1024;
   localparam int M_RUN = 0, M_SWAP = 1, M_DL = 2, M_REL = 3;

   logic        clk = 1'b0;
   logic        reset, ce_vid;
   logic [3:0]  cart_select;
   logic        dn_wr;
   logic [7:0]  dn_index, dn_data;
   logic [15:0] dn_addr, cpu_addr;
   logic        cpu_rd_n, cpu_mreq_n;
   logic [14:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata, mem_rdata, cpu_rdata;
   logic        cart_hit, sys_reset, busy;
   logic [15:0] dl_count;

   always #5 clk = ~clk;

   cart_swap_ctrl #(.ADDR_W(15), .CART_INDEX(8'd1), .SETTLE_CYCLES(S), .DL_IDLE_CYCLES(D)) dut (
      .clk(clk), .reset(reset), .ce_vid(ce_vid), .cart_select(cart_select),
      .dn_wr(dn_wr), .dn_index(dn_index), .dn_addr(dn_addr), .dn_data(dn_data),
      .cpu_addr(cpu_addr), .cpu_rd_n(cpu_rd_n), .cpu_mreq_n(cpu_mreq_n),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .cpu_rdata(cpu_rdata), .cart_hit(cart_hit), .sys_reset(sys_reset), .busy(busy),
      .dl_count(dl_count)
   );

   // cartridge memory attached to the DUT port
   logic [7:0] phys [0:32767];
   always @(posedge clk) begin
      if (mem_we) phys[mem_addr] <= mem_wdata;
      mem_rdata <= phys[mem_addr];
   end

   int n_cmp = 0, n_err = 0, cyc = 0;

   // reference model: mode plus absolute-cycle deadlines
   int       m_mode, swap_end, dl_last, m_dlc;
   bit       m_pend, m_hit, m_sysr, m_busy, m_rd_vld;
   logic [3:0] m_cur;
   logic [7:0] m_rd;
   logic [7:0] ref_mem [0:32767];
   bit         ref_vld [0:32767];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_cmp++;
      assert (obs === req) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, req, cyc);
      end
   endtask

   task automatic enter_dl(input bit mt);
      m_mode  = M_DL;
      dl_last = cyc;
      m_dlc   = mt ? 1 : 0;
   endtask

   task automatic tick();
      bit act, mt, sc, win;
      logic [15:0] off;
      logic [14:0] ea;
      ce_vid = (cyc % 5 == 0);
      #1;
      act = dn_wr && dn_index == 8'd1;
      mt  = act && !dn_addr[15];
      sc  = cart_select != m_cur;
      win = !cpu_mreq_n && !cpu_rd_n && cpu_addr >= 16'h4000 && cpu_addr <= 16'hBFFF;
      off = cpu_addr - 16'h4000;
      ea  = mt ? dn_addr[14:0] : off[14:0];
      chk("mem_we", {31'd0, mem_we}, {31'd0, (!reset && mt)});
      chk("mem_addr", {17'd0, mem_addr}, {17'd0, ea});
      if (mt) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, dn_data});
      if (!m_hit) chk("cpu_rdata_idle", {24'd0, cpu_rdata}, 32'd0);
      else if (m_rd_vld) chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, m_rd});
      @(posedge clk);
      if (reset) begin
         m_mode = M_REL; m_pend = 0; m_dlc = 0; m_hit = 0; m_sysr = 1; m_busy = 0;
      end else begin
         m_sysr   = (m_mode != M_RUN);
         m_busy   = (m_mode == M_SWAP || m_mode == M_DL);
         m_hit    = win;
         m_rd     = ref_mem[ea];
         m_rd_vld = ref_vld[ea];
         if (mt) begin ref_mem[ea] = dn_data; ref_vld[ea] = 1; end
         case (m_mode)
            M_RUN, M_REL: begin
               if (act) begin enter_dl(mt); m_pend = sc; end
               else if (sc) begin m_mode = M_SWAP; swap_end = cyc + S; end
               else if (m_mode == M_REL && ce_vid) m_mode = M_RUN;
            end
            M_SWAP: begin
               if (act) begin enter_dl(mt); m_pend = 1; end
               else if (sc) swap_end = cyc + S;
               else if (cyc == swap_end) m_mode = M_REL;
            end
            default: begin
               if (sc) m_pend = 1;
               if (act) begin
                  dl_last = cyc;
                  if (mt && m_dlc < 65535) m_dlc++;
               end else if (cyc == dl_last + D) begin
                  if (m_pend) begin m_mode = M_SWAP; swap_end = cyc + S; end
                  else m_mode = M_REL;
                  m_pend = 0;
               end
            end
         endcase
      end
      m_cur = cart_select;
      #1;
      chk("sys_reset", {31'd0, sys_reset}, {31'd0, m_sysr});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("cart_hit", {31'd0, cart_hit}, {31'd0, m_hit});
      chk("dl_count", {16'd0, dl_count}, m_dlc);
      @(negedge clk);
      cyc++;
   endtask

   task automatic quiet();
      dn_wr = 0; cpu_mreq_n = 1; cpu_rd_n = 1;
   endtask

   task automatic wr(input logic [7:0] idx, input logic [15:0] a, input logic [7:0] d);
      dn_wr = 1; dn_index = idx; dn_addr = a; dn_data = d;
      tick();
      dn_wr = 0;
   endtask

   task automatic rd(input logic [15:0] a);
      cpu_addr = a; cpu_mreq_n = 0; cpu_rd_n = 0;
      tick();
      cpu_mreq_n = 1; cpu_rd_n = 1;
   endtask

   task automatic run_until_run(input int max);
      int k = 0;
      while (m_mode != M_RUN && k < max) begin tick(); k++; end
      tick();
      chk("reached_run", {31'd0, sys_reset}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) ref_vld[i] = 0;
      m_mode = M_REL; m_pend = 0; m_dlc = 0; m_hit = 0; m_sysr = 1; m_busy = 0;
      m_rd = 0; m_rd_vld = 0; swap_end = 0; dl_last = 0;
      reset = 1; ce_vid = 0; cart_select = 4'd3; m_cur = 4'd3;
      dn_wr = 0; dn_index = 0; dn_addr = 0; dn_data = 0;
      cpu_addr = 0; cpu_rd_n = 1; cpu_mreq_n = 1;
      @(negedge clk);

      // power-on
      repeat (4) tick();
      chk("por_sys_reset", {31'd0, sys_reset}, 32'd1);
      chk("por_busy", {31'd0, busy}, 32'd0);
      reset = 0;
      run_until_run(50);

      // select change 3 -> 5
      cart_select = 4'd5;
      tick();
      tick();
      chk("swap_busy", {31'd0, busy}, 32'd1);
      run_until_run(60);

      // 300-byte download
      for (int i = 0; i < 300; i++) wr(8'd1, 16'(i), 8'(i));
      chk("dl_count_300", {16'd0, dl_count}, 32'd300);
      run_until_run(D + 50);

      // CPU reads
      rd(16'h4005);
      chk("rd_4005_hit", {31'd0, cart_hit}, 32'd1);
      chk("rd_4005_data", {24'd0, cpu_rdata}, 32'h05);
      rd(16'h412B);
      chk("rd_412b_data", {24'd0, cpu_rdata}, 32'h2B);
      rd(16'hC000);
      chk("rd_c000_hit", {31'd0, cart_hit}, 32'd0);
      chk("rd_c000_data", {24'd0, cpu_rdata}, 32'h00);
      rd(16'h3FFF);
      chk("rd_3fff_hit", {31'd0, cart_hit}, 32'd0);
      tick();

      // collision: select change during DL, then an out-of-range write
      wr(8'd1, 16'h0100, 8'hAA);
      cart_select = 4'd9;
      tick();
      wr(8'd1, 16'h8000, 8'h55);
      repeat (D + 2) tick();
      chk("collision_swap", {31'd0, busy}, 32'd1);
      run_until_run(60);

      // reset in the middle of a download
      wr(8'd1, 16'h0200, 8'h11);
      wr(8'd1, 16'h0201, 8'h22);
      reset = 1;
      wr(8'd1, 16'h0202, 8'h33);
      chk("rst_dl_count", {16'd0, dl_count}, 32'd0);
      reset = 0;
      run_until_run(60);

      // randomized traffic
      for (int i = 0; i < 5000; i++) begin
         dn_wr    = ($urandom_range(0, 255) < 3);
         dn_index = ($urandom_range(0, 3) == 0) ? 8'd2 : 8'd1;
         dn_addr  = {($urandom_range(0, 7) == 0), 6'd0, 9'($urandom_range(0, 511))};
         dn_data  = 8'($urandom);
         if ($urandom_range(0, 299) == 0) cart_select = 4'($urandom);
         reset    = ($urandom_range(0, 1999) == 0);
         cpu_mreq_n = $urandom_range(0, 1);
         cpu_rd_n   = $urandom_range(0, 1);
         case ($urandom_range(0, 2))
            0: cpu_addr = 16'h3F00 + 16'($urandom_range(0, 767));
            1: cpu_addr = 16'hBF00 + 16'($urandom_range(0, 511));
            default: cpu_addr = 16'($urandom);
         endcase
         tick();
      end
      reset = 0;
      quiet();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
